pipe_control_unit: RTL and testbench
====================================

// Module: pipe_control_unit
// PURPOSE
// - Pipelined successor of the single-cycle decoder: decodes OP_i in ID, registers the control bundle into ID/EX,
//   detects load-use hazards and sequences front-end flushes after a redirect from EX.
// - Sits between the IF/ID register and the EX datapath. Drives the ID/EX control fields, PC/IF-ID hold and bubble insertion.
// PARAMETERS
// - ALU_OP_W      4  ALU_Op width. Codes are zero-extended. Must be >=4 when ENABLE_AUIPC=1.
// - ENABLE_AUIPC  1  1: decode AUIPC (7'b0010111). 0: AUIPC is treated as illegal.
// - FLUSH_CYCLES  2  Bubbles inserted per redirect, including the redirect cycle. Range 1..7.
// - REG_ADDR_W    5  Register-index width.
// PORTS
// - clk          in   1           Clock, rising edge.
// - reset        in   1           Asynchronous reset, active-low.
// - OP_i         in   7           Opcode of the instruction in ID.
// - Rs1_i        in   REG_ADDR_W  rs1 index of the instruction in ID.
// - Rs2_i        in   REG_ADDR_W  rs2 index of the instruction in ID.
// - Rd_i         in   REG_ADDR_W  rd index of the instruction in ID.
// - Redirect_i   in   1           1-cycle pulse from EX: branch taken or jump target resolved.
// - Stall_o      out  1           Hold PC and IF/ID this cycle (combinational).
// - Flush_o      out  1           Kill IF/ID contents this cycle (combinational).
// - EX_Valid_o   out  1           ID/EX holds a real instruction (not a bubble).
// - EX_Rd_o      out  REG_ADDR_W  Registered rd.
// - EX_Jalr_o, EX_Jal_o, EX_Branch_o, EX_Mem_to_Reg_o, EX_Reg_Write_o,
//   EX_Mem_Read_o, EX_Mem_Write_o, EX_ALU_Src_o   out 1 each   Registered control bits.
// - EX_ALU_Op_o  out  ALU_OP_W    Registered ALU op code.
// - EX_Illegal_o out  1           Registered: the instruction now in EX had an undecoded opcode.
// BEHAVIOUR
// - Decode table. Bits are {Jalr,Jal,Branch,MemToReg,RegWr,MemRd,MemWr,ALUSrc}, followed by the ALU_Op code:
//   - R 0110011: 00001000, op 0
//   - I-logic 0010011: 00001001, op 1
//   - LUI 0110111: 00001001, op 2
//   - B 1100011: 00100000, op 3
//   - S 0100011: 00000011, op 4
//   - Load 0000011: 00011101, op 5
//   - JAL 1101111: 01101001, op 6
//   - JALR 1100111: 11101001, op 7
//   - AUIPC 0010111: 00001001, op 8
//   - Any other opcode: all zero, op 0, illegal=1.
// - Register usage:
//   - uses_rs1 = every legal opcode except LUI, JAL and AUIPC.
//   - uses_rs2 = R, B, S.
// - Load-use hazard (combinational): EX_Valid_o & EX_Mem_Read_o & (EX_Rd_o != 0) & ((uses_rs1 & Rs1_i == EX_Rd_o) | (uses_rs2 & Rs2_i == EX_Rd_o)).
// - Flush counter cnt (3 bits):
//   - Redirect_i loads cnt = FLUSH_CYCLES-1. A redirect arriving while cnt != 0 reloads it.
//   - Otherwise cnt decrements toward 0 and saturates at 0.
// - Flush and stall outputs:
//   - Flush_o = Redirect_i | (cnt != 0).
//   - Stall_o = hazard & ~Flush_o. Flush has priority; a stalled instruction that gets flushed is discarded.
// - ID/EX register update on each rising clk:
//   - Flush_o or Stall_o: load a bubble (all EX_* = 0, EX_Valid_o = 0, EX_Illegal_o = 0).
//   - Otherwise: load the decoded bundle, EX_Rd_o = Rd_i, EX_Valid_o = 1.
//   - Illegal opcode: EX_Valid_o = 1 and EX_Illegal_o = 1 with all control bits 0, so it has no architectural effect.
// - Latency: decode to EX_* outputs is 1 cycle. A stall holds exactly 1 cycle per load-use hazard, since the bubble clears EX_Mem_Read_o.
// - Reset (reset=0, asynchronous): all EX_* outputs = 0, cnt = 0. Stall_o and Flush_o then follow the inputs combinationally
//   (Flush_o = Redirect_i). Reset asserted mid-flush or mid-stall aborts it; first post-reset edge decodes normally.
// - No internal state other than the ID/EX bundle and cnt.
// TESTING
// - Reset: hold reset=0, toggle clk -> all EX_* = 0, Stall_o = 0. Release; drive OP_i=0110011, Rd_i=5 -> next edge: EX_Reg_Write_o=1, EX_ALU_Op_o=0, EX_Valid_o=1, EX_Rd_o=5.
// - Full decode sweep: every table opcode plus 7'b1111111, with ENABLE_AUIPC=0 and =1 -> EX bundle matches the table; AUIPC gives op 8 or illegal respectively.
// - Load-use: load with rd=3, then R with rs2=3 -> Stall_o=1 for 1 cycle, one bubble in EX, then the R instruction enters EX. Repeat with rd=0 -> no stall. Repeat with LUI consumer -> no stall.
// - Redirect, FLUSH_CYCLES=2: pulse Redirect_i -> Flush_o=1 for 2 cycles, 2 bubbles in EX. Second pulse during cnt=1 -> Flush_o extends 2 more cycles.
// - Simultaneous: hazard and Redirect_i in the same cycle -> Stall_o=0, Flush_o=1, bubble loaded.
// - Reset mid-flush: assert reset while cnt=1 -> cnt=0 immediately; after release Flush_o=0 with Redirect_i=0.

Source files
------------

// File: rtl/pipe_control_unit.sv
// rtl/pipe_control_unit.sv - ID-stage decode, ID/EX control register, load-use stall and redirect flush sequencing
module pipe_control_unit #(
   parameter int ALU_OP_W     = 4,
   parameter int ENABLE_AUIPC = 1,
   parameter int FLUSH_CYCLES = 2,
   parameter int REG_ADDR_W   = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [6:0]            OP_i,
   input  logic [REG_ADDR_W-1:0] Rs1_i,
   input  logic [REG_ADDR_W-1:0] Rs2_i,
   input  logic [REG_ADDR_W-1:0] Rd_i,
   input  logic                  Redirect_i,
   output logic                  Stall_o,
   output logic                  Flush_o,
   output logic                  EX_Valid_o,
   output logic [REG_ADDR_W-1:0] EX_Rd_o,
   output logic                  EX_Jalr_o,
   output logic                  EX_Jal_o,
   output logic                  EX_Branch_o,
   output logic                  EX_Mem_to_Reg_o,
   output logic                  EX_Reg_Write_o,
   output logic                  EX_Mem_Read_o,
   output logic                  EX_Mem_Write_o,
   output logic                  EX_ALU_Src_o,
   output logic [ALU_OP_W-1:0]   EX_ALU_Op_o,
   output logic                  EX_Illegal_o
);

   localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

   // {Jalr, Jal, Branch, MemToReg, RegWr, MemRd, MemWr, ALUSrc}
   logic [7:0]          dec_ctrl;
   logic [ALU_OP_W-1:0] dec_op;
   logic                dec_illegal;
   logic                uses_rs1;
   logic                uses_rs2;
   logic                hazard;
   logic [2:0]          cnt;

   // Opcode decode of the instruction currently sitting in ID
   always_comb begin
      dec_ctrl    = 8'b0000_0000;
      dec_op      = '0;
      dec_illegal = 1'b0;
      uses_rs1    = 1'b0;
      uses_rs2    = 1'b0;
      case (OP_i)
         7'b0110011: begin dec_ctrl = 8'b0000_1000; dec_op = ALU_OP_W'(4'd0); uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         7'b0010011: begin dec_ctrl = 8'b0000_1001; dec_op = ALU_OP_W'(4'd1); uses_rs1 = 1'b1; end
         7'b0110111: begin dec_ctrl = 8'b0000_1001; dec_op = ALU_OP_W'(4'd2); end
         7'b1100011: begin dec_ctrl = 8'b0010_0000; dec_op = ALU_OP_W'(4'd3); uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         7'b0100011: begin dec_ctrl = 8'b0000_0011; dec_op = ALU_OP_W'(4'd4); uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         7'b0000011: begin dec_ctrl = 8'b0001_1101; dec_op = ALU_OP_W'(4'd5); uses_rs1 = 1'b1; end
         7'b1101111: begin dec_ctrl = 8'b0110_1001; dec_op = ALU_OP_W'(4'd6); end
         7'b1100111: begin dec_ctrl = 8'b1110_1001; dec_op = ALU_OP_W'(4'd7); uses_rs1 = 1'b1; end
         7'b0010111: begin
            if (ENABLE_AUIPC != 0) begin
               dec_ctrl = 8'b0000_1001;
               dec_op   = ALU_OP_W'(4'd8);
            end else begin
               dec_illegal = 1'b1;
            end
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   // Load-use hazard against the load now in EX; x0 is never a real dependency
   always_comb begin
      hazard = EX_Valid_o & EX_Mem_Read_o & (EX_Rd_o != '0) &
               ((uses_rs1 & (Rs1_i == EX_Rd_o)) | (uses_rs2 & (Rs2_i == EX_Rd_o)));
   end

   assign Flush_o = Redirect_i | (cnt != 3'd0);
   assign Stall_o = hazard & ~Flush_o;

   // Flush counter: a redirect (re)loads it, otherwise it drains to zero
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= 3'd0;
      end else if (Redirect_i) begin
         cnt <= CNT_LOAD;
      end else if (cnt != 3'd0) begin
         cnt <= cnt - 3'd1;
      end
   end

   // ID/EX control register: bubble on flush or stall, else the decoded bundle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         EX_Valid_o      <= 1'b0;
         EX_Illegal_o    <= 1'b0;
         EX_Rd_o         <= '0;
         EX_ALU_Op_o     <= '0;
         {EX_Jalr_o, EX_Jal_o, EX_Branch_o, EX_Mem_to_Reg_o,
          EX_Reg_Write_o, EX_Mem_Read_o, EX_Mem_Write_o, EX_ALU_Src_o} <= 8'b0;
      end else if (Flush_o || Stall_o) begin
         EX_Valid_o      <= 1'b0;
         EX_Illegal_o    <= 1'b0;
         EX_Rd_o         <= '0;
         EX_ALU_Op_o     <= '0;
         {EX_Jalr_o, EX_Jal_o, EX_Branch_o, EX_Mem_to_Reg_o,
          EX_Reg_Write_o, EX_Mem_Read_o, EX_Mem_Write_o, EX_ALU_Src_o} <= 8'b0;
      end else begin
         EX_Valid_o      <= 1'b1;
         EX_Illegal_o    <= dec_illegal;
         EX_Rd_o         <= Rd_i;
         EX_ALU_Op_o     <= dec_op;
         {EX_Jalr_o, EX_Jal_o, EX_Branch_o, EX_Mem_to_Reg_o,
          EX_Reg_Write_o, EX_Mem_Read_o, EX_Mem_Write_o, EX_ALU_Src_o} <= dec_ctrl;
      end
   end

endmodule

// File: tb/tb_pipe_control_unit.sv
// tb/tb_pipe_control_unit.sv - directed-vector bench for pipe_control_unit
module tb_pipe_control_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [4:0] rs1, rs2, rd;
   logic       redirect;

   logic       stall_a, flush_a, valid_a, ill_a;
   logic [4:0] exrd_a;
   logic       jalr_a, jal_a, br_a, m2r_a, rw_a, mr_a, mw_a, src_a;
   logic [3:0] aop_a;

   logic       stall_b, flush_b, valid_b, ill_b;
   logic [4:0] exrd_b;
   logic       jalr_b, jal_b, br_b, m2r_b, rw_b, mr_b, mw_b, src_b;
   logic [3:0] aop_b;

   logic [13:0] vec_a, vec_b;
   assign vec_a = {valid_a, ill_a, jalr_a, jal_a, br_a, m2r_a, rw_a, mr_a, mw_a, src_a, aop_a};
   assign vec_b = {valid_b, ill_b, jalr_b, jal_b, br_b, m2r_b, rw_b, mr_b, mw_b, src_b, aop_b};

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipe_control_unit #(.ALU_OP_W(4), .ENABLE_AUIPC(1), .FLUSH_CYCLES(2), .REG_ADDR_W(5)) dut_a (
      .clk(clk), .reset(reset), .OP_i(op), .Rs1_i(rs1), .Rs2_i(rs2), .Rd_i(rd), .Redirect_i(redirect),
      .Stall_o(stall_a), .Flush_o(flush_a), .EX_Valid_o(valid_a), .EX_Rd_o(exrd_a),
      .EX_Jalr_o(jalr_a), .EX_Jal_o(jal_a), .EX_Branch_o(br_a), .EX_Mem_to_Reg_o(m2r_a),
      .EX_Reg_Write_o(rw_a), .EX_Mem_Read_o(mr_a), .EX_Mem_Write_o(mw_a), .EX_ALU_Src_o(src_a),
      .EX_ALU_Op_o(aop_a), .EX_Illegal_o(ill_a)
   );

   pipe_control_unit #(.ALU_OP_W(4), .ENABLE_AUIPC(0), .FLUSH_CYCLES(2), .REG_ADDR_W(5)) dut_b (
      .clk(clk), .reset(reset), .OP_i(op), .Rs1_i(rs1), .Rs2_i(rs2), .Rd_i(rd), .Redirect_i(redirect),
      .Stall_o(stall_b), .Flush_o(flush_b), .EX_Valid_o(valid_b), .EX_Rd_o(exrd_b),
      .EX_Jalr_o(jalr_b), .EX_Jal_o(jal_b), .EX_Branch_o(br_b), .EX_Mem_to_Reg_o(m2r_b),
      .EX_Reg_Write_o(rw_b), .EX_Mem_Read_o(mr_b), .EX_Mem_Write_o(mw_b), .EX_ALU_Src_o(src_b),
      .EX_ALU_Op_o(aop_b), .EX_Illegal_o(ill_b)
   );

   // Decode table: opcode, control byte, ALU op, illegal
   logic [6:0] opc_tab [10] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b1100011, 7'b0100011,
                                7'b0000011, 7'b1101111, 7'b1100111, 7'b0010111, 7'b1111111};
   logic [7:0] ctl_tab [10] = '{8'b00001000, 8'b00001001, 8'b00001001, 8'b00100000, 8'b00000011,
                                8'b00011101, 8'b01101001, 8'b11101001, 8'b00001001, 8'b00000000};
   logic [3:0] aop_tab [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd0};
   logic       ill_tab [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   localparam logic [13:0] BUBBLE = 14'd0;
   localparam logic [13:0] EXP_R   = {1'b1, 1'b0, 8'b00001000, 4'd0};
   localparam logic [13:0] EXP_LUI = {1'b1, 1'b0, 8'b00001001, 4'd2};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [6:0] o, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input logic rdr);
      op = o; rs1 = s1; rs2 = s2; rd = d; redirect = rdr;
      #1;
   endtask

   initial begin
      reset = 1'b0;
      drive(7'b0110011, 5'd0, 5'd0, 5'd5, 1'b0);
      tick(); tick();
      check("rst_vec", 32'(vec_a), 32'(BUBBLE));
      check("rst_rd", 32'(exrd_a), 32'd0);
      check("rst_stall", 32'(stall_a), 32'd0);
      check("rst_flush", 32'(flush_a), 32'd0);

      reset = 1'b1;
      tick();
      check("post_rst_vec", 32'(vec_a), 32'(EXP_R));
      check("post_rst_rd", 32'(exrd_a), 32'd5);

      // decode sweep on both AUIPC variants
      for (int i = 0; i < 10; i++) begin
         drive(opc_tab[i], 5'd0, 5'd0, 5'(i + 1), 1'b0);
         tick();
         check($sformatf("dec_a_%0d", i), 32'(vec_a),
               32'({1'b1, ill_tab[i], ctl_tab[i], aop_tab[i]}));
         check($sformatf("dec_rd_%0d", i), 32'(exrd_a), 32'(i + 1));
         if (i == 8)
            check("dec_b_auipc", 32'(vec_b), 32'({1'b1, 1'b1, 8'b0, 4'd0}));
         else
            check($sformatf("dec_b_%0d", i), 32'(vec_b),
                  32'({1'b1, ill_tab[i], ctl_tab[i], aop_tab[i]}));
      end

      // load-use: load rd=3 then R reading rs2=3
      drive(7'b0000011, 5'd0, 5'd0, 5'd3, 1'b0);
      tick();
      drive(7'b0110011, 5'd0, 5'd3, 5'd7, 1'b0);
      check("lu_stall", 32'(stall_a), 32'd1);
      check("lu_flush", 32'(flush_a), 32'd0);
      tick();
      check("lu_bubble", 32'(vec_a), 32'(BUBBLE));
      check("lu_stall_clear", 32'(stall_a), 32'd0);
      tick();
      check("lu_r_enters", 32'(vec_a), 32'(EXP_R));
      check("lu_r_rd", 32'(exrd_a), 32'd7);

      // load to x0: no dependency
      drive(7'b0000011, 5'd0, 5'd0, 5'd0, 1'b0);
      tick();
      drive(7'b0110011, 5'd0, 5'd0, 5'd8, 1'b0);
      check("lu_x0_stall", 32'(stall_a), 32'd0);
      tick();
      check("lu_x0_r", 32'(vec_a), 32'(EXP_R));

      // LUI consumer reads no registers
      drive(7'b0000011, 5'd0, 5'd0, 5'd3, 1'b0);
      tick();
      drive(7'b0110111, 5'd3, 5'd3, 5'd9, 1'b0);
      check("lu_lui_stall", 32'(stall_a), 32'd0);
      tick();
      check("lu_lui_ex", 32'(vec_a), 32'(EXP_LUI));

      // single redirect: two bubbles
      drive(7'b0110011, 5'd0, 5'd0, 5'd9, 1'b1);
      check("rd1_flush0", 32'(flush_a), 32'd1);
      tick();
      drive(7'b0110011, 5'd0, 5'd0, 5'd9, 1'b0);
      check("rd1_bub0", 32'(vec_a), 32'(BUBBLE));
      check("rd1_flush1", 32'(flush_a), 32'd1);
      tick();
      check("rd1_bub1", 32'(vec_a), 32'(BUBBLE));
      check("rd1_flush_end", 32'(flush_a), 32'd0);
      tick();
      check("rd1_resume", 32'(vec_a), 32'(EXP_R));

      // second redirect while cnt=1 extends the flush
      drive(7'b0110011, 5'd0, 5'd0, 5'd9, 1'b1);
      tick();
      drive(7'b0110011, 5'd0, 5'd0, 5'd9, 1'b1);
      check("rd2_flush_pulse2", 32'(flush_a), 32'd1);
      tick();
      drive(7'b0110011, 5'd0, 5'd0, 5'd9, 1'b0);
      check("rd2_flush_ext", 32'(flush_a), 32'd1);
      check("rd2_bub", 32'(vec_a), 32'(BUBBLE));
      tick();
      check("rd2_flush_end", 32'(flush_a), 32'd0);
      check("rd2_bub2", 32'(vec_a), 32'(BUBBLE));
      tick();
      check("rd2_resume", 32'(vec_a), 32'(EXP_R));

      // hazard and redirect together: flush wins
      drive(7'b0000011, 5'd0, 5'd0, 5'd4, 1'b0);
      tick();
      drive(7'b0110011, 5'd4, 5'd0, 5'd6, 1'b1);
      check("sim_stall", 32'(stall_a), 32'd0);
      check("sim_flush", 32'(flush_a), 32'd1);
      tick();
      drive(7'b0110011, 5'd4, 5'd0, 5'd6, 1'b0);
      check("sim_bubble", 32'(vec_a), 32'(BUBBLE));
      tick();
      tick();
      check("sim_resume", 32'(vec_a), 32'(EXP_R));

      // reset in the middle of a flush
      drive(7'b0110011, 5'd0, 5'd0, 5'd2, 1'b1);
      tick();
      drive(7'b0110011, 5'd0, 5'd0, 5'd2, 1'b0);
      check("mid_flush_before", 32'(flush_a), 32'd1);
      reset = 1'b0;
      #1;
      check("mid_flush_cleared", 32'(flush_a), 32'd0);
      check("mid_flush_vec", 32'(vec_a), 32'(BUBBLE));
      #2;
      reset = 1'b1;
      #1;
      check("mid_flush_release", 32'(flush_a), 32'd0);
      tick();
      check("mid_flush_decode", 32'(vec_a), 32'(EXP_R));
      check("mid_flush_rd", 32'(exrd_a), 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
